// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier.
// FSM encoding and default product width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int PW        = 2 * WIDTH_DEF;

endpackage

// File: rtl/seq_mult_4bit_add.sv
// One shift-and-add step: WIDTH-bit ripple add with carry out.
// Reused by every iteration of the multiplier.
module mult_add_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] addend,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, acc_hi}
                     + {1'b0, addend}
                     + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_mult_4bit.sv
// Sequential unsigned shift-and-add multiplier.
// One adder reused for WIDTH steps; valid/ready on both sides.
module seq_mult_4bit
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state, state_n;

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [CW-1:0]    count;
  logic             last;

  assign addend    = mq[0] ? mcand : '0;
  assign last      = (count == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  mult_add_step #(
    .WIDTH (WIDTH)
  ) u_add (
    .acc_hi (acc_hi),
    .addend (addend),
    .cin    (1'b0),
    .sum    (sum),
    .cout   (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == IDLE): if (in_valid)  state_n = CALC;
      (state == CALC): if (last)      state_n = DONE;
      (state == DONE): if (out_ready) state_n = IDLE;
      default:                        state_n = IDLE;
    endcase
  end

  // {carry, sum, mq} shifted right by one; old mq[0] falls off
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi  <= '0;
      mq      <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else if (in_valid && in_ready) begin
      mcand  <= a;
      mq     <= b;
      acc_hi <= '0;
      count  <= '0;
    end else if (state == CALC) begin
      acc_hi <= {carry, sum[WIDTH-1:1]};
      mq     <= {sum[0], mq[WIDTH-1:1]};
      count  <= count + CW'(1);
      if (last) product <= {carry, sum, mq[WIDTH-1:1]};
    end
  end

endmodule
